// File: rtl/alu_9bit_pkg.sv
// Shared types and sizes for the alu_9bit operand arbitration path.
package alu_9bit_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux_9bit.sv
// 4:1 multiplexer of 9-bit operands shared by the alu_9bit requesters.
module mux_9bit (
    input  logic [8:0] a_i,
    input  logic [8:0] b_i,
    input  logic [8:0] c_i,
    input  logic [8:0] d_i,
    input  logic [1:0] sel_i,
    output logic [8:0] y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = a_i;
            2'd1:    y_o = b_i;
            2'd2:    y_o = c_i;
            default: y_o = d_i;
        endcase
    end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational winner pick over four requests: round-robin from ptr_i,
// or fixed priority with index 0 highest when fixed_i is set.
module rr_pick_4
    import alu_9bit_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             fixed_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

    // Scan from the far end so the nearest asserted request overwrites last.
    always_comb begin
        winner_o = '0;
        any_o    = |req_i;
        if (fixed_i) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req_i[i]) winner_o = SEL_W'(i);
            end
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req_i[ptr_i + SEL_W'(k)]) winner_o = ptr_i + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_9bit_rr_arbiter.sv
// Shares one mux_9bit between four requesters: arbitrates the select,
// registers the chosen operand on a valid/ready port and pulses done.
module mux_9bit_rr_arbiter
    import alu_9bit_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter bit PRIO_FIXED = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic [WIDTH-1:0] data_b_i,
    input  logic [WIDTH-1:0] data_c_i,
    input  logic [WIDTH-1:0] data_d_i,
    input  logic             out_ready_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [SEL_W-1:0] select_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [N_REQ-1:0] done_o,
    output logic [CNT_W-1:0] xfer_count_o
);

    arb_state_t       state_q;
    logic [SEL_W-1:0] select_q;
    logic [N_REQ-1:0] grant_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [N_REQ-1:0] done_q;
    logic [CNT_W-1:0] count_q;
    logic [SEL_W-1:0] rr_ptr_q;

    logic [N_REQ-1:0] pick_req_d;
    logic [SEL_W-1:0] pick_ptr_d;
    logic [SEL_W-1:0] pick_winner;
    logic             pick_any;
    logic [WIDTH-1:0] mux_out;

    mux_9bit u_mux (
        .a_i  (data_a_i),
        .b_i  (data_b_i),
        .c_i  (data_c_i),
        .d_i  (data_d_i),
        .sel_i(select_q),
        .y_o  (mux_out)
    );

    // On acceptance the served requester is masked out and the pointer is
    // already advanced past it, so the back-to-back pick never repeats it.
    always_comb begin
        pick_req_d = req_i;
        pick_ptr_d = rr_ptr_q;
        if (state_q == HOLD) begin
            pick_req_d = req_i & ~grant_q;
            pick_ptr_d = select_q + SEL_W'(1);
        end
    end

    rr_pick_4 u_pick (
        .req_i   (pick_req_d),
        .ptr_i   (pick_ptr_d),
        .fixed_i (PRIO_FIXED),
        .winner_o(pick_winner),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            select_q <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        select_q <= pick_winner;
                        grant_q  <= onehot(pick_winner);
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    data_q  <= mux_out;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        done_q   <= onehot(select_q);
                        count_q  <= count_q + CNT_W'(1);
                        rr_ptr_q <= select_q + SEL_W'(1);
                        valid_q  <= 1'b0;
                        if (pick_any) begin
                            select_q <= pick_winner;
                            grant_q  <= onehot(pick_winner);
                            state_q  <= LOAD;
                        end else begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign select_o     = select_q;
    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign done_o       = done_q;
    assign xfer_count_o = count_q;

endmodule

// File: tb/tb_mux_9bit_rr_arbiter.sv
// Bench for mux_9bit_rr_arbiter: a round-robin instance (16-bit count) and a
// fixed-priority instance (4-bit count, to reach the wrap quickly).
module tb_mux_9bit_rr_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [8:0] data;
    } exp_t;

    typedef struct {
        int         idx;
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] c;
        logic [8:0] d;
        logic [3:0] expGrant;
        logic [8:0] expData;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic [8:0] dataV   [4];
    logic [3:0] reqV    [2];
    logic       readyV  [2];
    logic [3:0] grantV  [2];
    logic [1:0] selV    [2];
    logic       validV  [2];
    logic [8:0] outV    [2];
    logic [3:0] doneV   [2];
    logic [15:0] xferR;
    logic [3:0]  xferF;

    int   remV   [2][4];
    int   expCnt [2];
    exp_t sbR[$];
    exp_t sbF[$];
    int   acceptCyc[$];
    int   tests;
    int   fails;
    int   cycle;
    vec_t vecs [6];

    mux_9bit_rr_arbiter #(.WIDTH(9), .PRIO_FIXED(1'b0), .CNT_W(16)) dutRr (
        .clk         (clk),
        .rst_n       (rstN),
        .req_i       (reqV[0]),
        .data_a_i    (dataV[0]),
        .data_b_i    (dataV[1]),
        .data_c_i    (dataV[2]),
        .data_d_i    (dataV[3]),
        .out_ready_i (readyV[0]),
        .grant_o     (grantV[0]),
        .select_o    (selV[0]),
        .out_valid_o (validV[0]),
        .out_data_o  (outV[0]),
        .done_o      (doneV[0]),
        .xfer_count_o(xferR)
    );

    mux_9bit_rr_arbiter #(.WIDTH(9), .PRIO_FIXED(1'b1), .CNT_W(4)) dutFx (
        .clk         (clk),
        .rst_n       (rstN),
        .req_i       (reqV[1]),
        .data_a_i    (dataV[0]),
        .data_b_i    (dataV[1]),
        .data_c_i    (dataV[2]),
        .data_d_i    (dataV[3]),
        .out_ready_i (readyV[1]),
        .grant_o     (grantV[1]),
        .select_o    (selV[1]),
        .out_valid_o (validV[1]),
        .out_data_o  (outV[1]),
        .done_o      (doneV[1]),
        .xfer_count_o(xferF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input int idx, input logic [8:0] expData);
        exp_t e;
        e.grant = 4'b0001 << idx;
        e.data  = expData;
        reqV[d][idx] = 1'b1;
        remV[d][idx]++;
        if (d == 0) sbR.push_back(e);
        else        sbF.push_back(e);
    endtask

    // One clock: score acceptances seen before the edge, then check done,
    // count and the requester protocol after it.
    task automatic stepCycle();
        logic [3:0] expD [2];
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            expD[d] = '0;
            if (validV[d] && readyV[d]) begin
                if ((d == 0 && sbR.size() == 0) || (d == 1 && sbF.size() == 0)) begin
                    checkOutput($sformatf("dut%0d unexpected transfer", d), 1, 0);
                end else begin
                    if (d == 0) e = sbR.pop_front();
                    else        e = sbF.pop_front();
                    checkOutput($sformatf("dut%0d grant", d), grantV[d], e.grant);
                    checkOutput($sformatf("dut%0d out_data", d), outV[d], e.data);
                    expD[d] = e.grant;
                    expCnt[d]++;
                    if (d == 0) acceptCyc.push_back(cycle);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d done", d), doneV[d], expD[d]);
            for (int i = 0; i < 4; i++) begin
                if (expD[d][i]) begin
                    remV[d][i]--;
                    if (remV[d][i] <= 0) reqV[d][i] = 1'b0;
                end
            end
        end
        checkOutput("dut0 xfer_count", xferR, expCnt[0] % 65536);
        checkOutput("dut1 xfer_count", xferF, expCnt[1] % 16);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("dut%0d grant without req", d), grantV[d] & ~reqV[d], 0);
    endtask

    function automatic bit isIdle();
        return sbR.size() == 0 && sbF.size() == 0 && reqV[0] == 4'b0 && reqV[1] == 4'b0 &&
               !validV[0] && !validV[1] && grantV[0] == 4'b0 && grantV[1] == 4'b0;
    endfunction

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!isIdle() && n < budget) begin
            stepCycle();
            n++;
        end
        if (!isIdle()) checkOutput("idle timeout", 1, 0);
    endtask

    task automatic checkAllZero(input int d, input string tag);
        checkOutput($sformatf("%s dut%0d grant", tag, d), grantV[d], 0);
        checkOutput($sformatf("%s dut%0d select", tag, d), selV[d], 0);
        checkOutput($sformatf("%s dut%0d out_valid", tag, d), validV[d], 0);
        checkOutput($sformatf("%s dut%0d out_data", tag, d), outV[d], 0);
        checkOutput($sformatf("%s dut%0d done", tag, d), doneV[d], 0);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        cycle  = 0;
        expCnt = '{0, 0};
        rstN   = 1'b1;
        reqV   = '{4'b0, 4'b0};
        readyV = '{1'b0, 1'b0};
        dataV  = '{9'd0, 9'd0, 9'd0, 9'd0};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) remV[d][i] = 0;

        vecs[0] = '{0, 9'h011, 9'h022, 9'h033, 9'h044, 4'b0001, 9'h011};
        vecs[1] = '{1, 9'h1FF, 9'h000, 9'h155, 9'h0AA, 4'b0010, 9'h000};
        vecs[2] = '{2, 9'h0AA, 9'h155, 9'h1FF, 9'h000, 4'b0100, 9'h1FF};
        vecs[3] = '{3, 9'h001, 9'h002, 9'h004, 9'h100, 4'b1000, 9'h100};
        vecs[4] = '{2, 9'h123, 9'h045, 9'h067, 9'h089, 4'b0100, 9'h067};
        vecs[5] = '{3, 9'h0F0, 9'h10F, 9'h1E1, 9'h01E, 4'b1000, 9'h01E};

        // Power-on reset.
        #3 rstN = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) checkAllZero(d, "por");
        checkOutput("por xfer dut0", xferR, 0);
        checkOutput("por xfer dut1", xferF, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Asynchronous reset while holding an unaccepted operand.
        dataV = '{9'd1, 9'd2, 9'd3, 9'd4};
        applyStimulus(0, 0, 9'd1);
        stepCycle();
        stepCycle();
        checkOutput("pre-reset out_valid", validV[0], 1);
        checkOutput("pre-reset out_data", outV[0], 9'd1);
        #2 rstN = 1'b0;
        #1;
        checkAllZero(0, "async reset");
        checkOutput("async reset xfer", xferR, 0);
        sbR.delete();
        reqV[0] = 4'b0;
        for (int i = 0; i < 4; i++) remV[0][i] = 0;
        @(posedge clk);
        #1 rstN = 1'b1;

        // Single request latency: select at N+1, data at N+2, done at N+3.
        readyV[0] = 1'b1;
        applyStimulus(0, 2, 9'd3);
        stepCycle();
        checkOutput("lat N+1 select", selV[0], 2);
        checkOutput("lat N+1 grant", grantV[0], 4'b0100);
        checkOutput("lat N+1 out_valid", validV[0], 0);
        stepCycle();
        checkOutput("lat N+2 out_valid", validV[0], 1);
        checkOutput("lat N+2 out_data", outV[0], 9'd3);
        stepCycle();
        checkOutput("lat N+3 done", doneV[0], 4'b0100);
        checkOutput("lat N+3 xfer", xferR, 1);
        waitIdle(10);

        // Table of single requests applied to both instances.
        readyV[1] = 1'b1;
        for (int v = 0; v < 6; v++) begin
            dataV = '{vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d};
            for (int d = 0; d < 2; d++) applyStimulus(d, vecs[v].idx, vecs[v].expData);
            stepCycle();
            checkOutput($sformatf("vec%0d grant", v), grantV[0], vecs[v].expGrant);
            waitIdle(20);
        end

        // Round-robin with all four requesting; requester 0 wants two transfers.
        dataV = '{9'd1, 9'd2, 9'd3, 9'd4};
        acceptCyc.delete();
        applyStimulus(0, 0, 9'd1);
        applyStimulus(0, 1, 9'd2);
        applyStimulus(0, 2, 9'd3);
        applyStimulus(0, 3, 9'd4);
        applyStimulus(0, 0, 9'd1);
        waitIdle(40);
        checkOutput("rr transfer count", acceptCyc.size(), 5);
        if (acceptCyc.size() == 5)
            for (int k = 1; k < 5; k++)
                checkOutput($sformatf("rr spacing %0d", k), acceptCyc[k] - acceptCyc[k-1], 2);

        // Backpressure: operand and grant hold steady, one done on release.
        dataV[1]  = 9'h077;
        readyV[0] = 1'b0;
        applyStimulus(0, 1, 9'h077);
        for (int n = 0; n < 5 && !validV[0]; n++) stepCycle();
        checkOutput("bp reached HOLD", validV[0], 1);
        for (int n = 0; n < 5; n++) begin
            stepCycle();
            checkOutput("bp out_valid", validV[0], 1);
            checkOutput("bp out_data", outV[0], 9'h077);
            checkOutput("bp grant", grantV[0], 4'b0010);
        end
        readyV[0] = 1'b1;
        waitIdle(10);
        stepCycle();

        // Late request during LOAD of requester 0, then pointer wrap 3->0.
        dataV = '{9'd5, 9'd6, 9'd7, 9'd9};
        applyStimulus(0, 0, 9'd5);
        stepCycle();
        checkOutput("late grant0", grantV[0], 4'b0001);
        applyStimulus(0, 3, 9'd9);
        waitIdle(20);
        applyStimulus(0, 0, 9'd5);
        applyStimulus(0, 1, 9'd6);
        waitIdle(20);

        // Fixed priority: lowest index wins among the non-served requesters.
        dataV = '{9'h101, 9'h102, 9'h103, 9'h104};
        applyStimulus(1, 0, 9'h101);
        applyStimulus(1, 1, 9'h102);
        applyStimulus(1, 0, 9'h101);
        applyStimulus(1, 3, 9'h104);
        waitIdle(30);

        // Counter wrap on the 4-bit instance.
        for (int k = 0; k < 20 && (expCnt[1] % 16) != 15; k++) begin
            applyStimulus(1, 2, 9'h103);
            waitIdle(10);
        end
        checkOutput("dut1 xfer before wrap", xferF, 4'hF);
        applyStimulus(1, 2, 9'h103);
        waitIdle(10);
        checkOutput("dut1 xfer wrap", xferF, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
